// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine.
package mandelbrot_pkg;

    localparam int unsigned TAG_W   = 11;
    localparam int unsigned LIMIT_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // 4.0 in a FRAC-fraction-bit format; callers size it down to their product width.
    function automatic logic [LIMIT_W-1:0] escape_limit(input int unsigned frac);
        logic [LIMIT_W-1:0] four;
        four    = '0;
        four[2] = 1'b1;
        return four << frac;
    endfunction

endpackage

// File: rtl/mandelbrot_iterator_if.sv
// Point-in / result-out handshake bundle between mapper, engine and colour stage.
interface mandelbrot_iterator_if #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned ITER_W      = 16
);
    import mandelbrot_pkg::*;

    logic                          c_valid;
    logic                          c_ready;
    logic signed [WORD_LENGTH-1:0] c_re;
    logic signed [WORD_LENGTH-1:0] c_im;
    logic [TAG_W-1:0]              x_in;
    logic [TAG_W-1:0]              y_in;
    logic [ITER_W-1:0]             max_iter;
    logic                          out_valid;
    logic                          out_ready;
    logic [ITER_W-1:0]             iter_count;
    logic                          escaped;
    logic [TAG_W-1:0]              x_out;
    logic [TAG_W-1:0]              y_out;

    modport master (
        output c_valid, c_re, c_im, x_in, y_in, max_iter, out_ready,
        input  c_ready, out_valid, iter_count, escaped, x_out, y_out
    );

    modport slave (
        input  c_valid, c_re, c_im, x_in, y_in, max_iter, out_ready,
        output c_ready, out_valid, iter_count, escaped, x_out, y_out
    );

endinterface

// File: rtl/fx_mul.sv
// Signed fixed-point multiply: full product plus the FRAC-shifted (floor) result.
module fx_mul #(
    parameter int unsigned W    = 34,
    parameter int unsigned FRAC = 28
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] prod,
    output logic signed [W-1:0]   scaled
);
    localparam int unsigned P_W = 2 * W;

    assign prod   = P_W'(a) * P_W'(b);
    assign scaled = W'(prod >>> FRAC);

endmodule

// File: rtl/mandelbrot_iterator.sv
// Escape-time iterator: z <- z^2 + c, one step per clock, until |z|^2 > 4 or the limit.
module mandelbrot_iterator
    import mandelbrot_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned FRAC        = 28,
    parameter int unsigned ITER_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mandelbrot_iterator_if.slave bus
);
    localparam int unsigned Z_W    = WORD_LENGTH + 2;
    localparam int unsigned PROD_W = 2 * Z_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam logic signed [PROD_W-1:0] ESC_LIMIT = PROD_W'(escape_limit(FRAC));

    state_t state_q, state_d;

    logic signed [WORD_LENGTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
    logic signed [Z_W-1:0]         z_re_q, z_re_d, z_im_q, z_im_d;
    logic [ITER_W-1:0]             count_q, count_d, limit_q, limit_d;
    logic [ITER_W-1:0]             iter_count_q, iter_count_d;
    logic [TAG_W-1:0]              x_out_q, x_out_d, y_out_q, y_out_d;
    logic                          ready_q, ready_d;
    logic                          out_valid_q, out_valid_d;
    logic                          escaped_q, escaped_d;

    logic signed [PROD_W-1:0] re2_full, im2_full, reim_full_unused;
    logic signed [Z_W-1:0]    re2, im2, reim;
    logic signed [SUM_W-1:0]  mag_full;
    logic signed [PROD_W-1:0] mag;

    fx_mul #(.W(Z_W), .FRAC(FRAC)) u_mul_re2 (
        .a(z_re_q), .b(z_re_q), .prod(re2_full), .scaled(re2)
    );

    fx_mul #(.W(Z_W), .FRAC(FRAC)) u_mul_im2 (
        .a(z_im_q), .b(z_im_q), .prod(im2_full), .scaled(im2)
    );

    // Cross term uses the truncated product; its full-width form is not needed.
    fx_mul #(.W(Z_W), .FRAC(FRAC)) u_mul_reim (
        .a(z_re_q), .b(z_im_q), .prod(reim_full_unused), .scaled(reim)
    );

    // Sum before truncation, one guard bit so the escape test never wraps.
    assign mag_full = SUM_W'(re2_full) + SUM_W'(im2_full);
    assign mag      = PROD_W'(mag_full >>> FRAC);

    always_comb begin
        state_d      = state_q;
        c_re_d       = c_re_q;
        c_im_d       = c_im_q;
        z_re_d       = z_re_q;
        z_im_d       = z_im_q;
        count_d      = count_q;
        limit_d      = limit_q;
        iter_count_d = iter_count_q;
        escaped_d    = escaped_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (bus.c_valid && ready_q) begin
                    c_re_d  = bus.c_re;
                    c_im_d  = bus.c_im;
                    x_out_d = bus.x_in;
                    y_out_d = bus.y_in;
                    limit_d = bus.max_iter;
                    z_re_d  = '0;
                    z_im_d  = '0;
                    count_d = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                out_valid_d = 1'b0;
                if (count_q == limit_q) begin
                    iter_count_d = count_q;
                    escaped_d    = 1'b0;
                    state_d      = DONE;
                end else if (mag > ESC_LIMIT) begin
                    iter_count_d = count_q;
                    escaped_d    = 1'b1;
                    state_d      = DONE;
                end else begin
                    z_re_d  = Z_W'(re2 - im2 + Z_W'(c_re_q));
                    z_im_d  = Z_W'((reim <<< 1) + Z_W'(c_im_q));
                    count_d = count_q + ITER_W'(1);
                end
            end
            DONE: begin
                // Result is presented one cycle after DONE is entered.
                out_valid_d = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            escaped_q    <= 1'b0;
            iter_count_q <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            z_re_q       <= '0;
            z_im_q       <= '0;
            count_q      <= '0;
            limit_q      <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            out_valid_q  <= out_valid_d;
            escaped_q    <= escaped_d;
            iter_count_q <= iter_count_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            c_re_q       <= c_re_d;
            c_im_q       <= c_im_d;
            z_re_q       <= z_re_d;
            z_im_q       <= z_im_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
        end
    end

    assign bus.c_ready    = ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.iter_count = iter_count_q;
    assign bus.escaped    = escaped_q;
    assign bus.x_out      = x_out_q;
    assign bus.y_out      = y_out_q;

endmodule

// File: doc/mandelbrot_iterator.md
# mandelbrot_iterator

Per-pixel escape-time engine directly downstream of the pixel-to-complex mapper. Accepts one complex point c (fixed-point real/imag plus its pixel x/y tag) and iterates z ← z² + c from z = 0 at one iteration per clock. It stops on escape (|z|² > 4.0) or at the iteration limit, then presents the iteration count and tag to the colour-mapping stage over a valid/ready handshake.

## Interface
Parameters:
- WORD_LENGTH, 32, width of signed fixed-point c inputs
- FRAC, 28, fractional bits of all fixed-point values (Q(WORD_LENGTH-FRAC).FRAC)
- ITER_W, 16, width of iteration limit and count

Ports:
- clk  in  1  single clock; everything on rising edge
- rst_n  in  1  synchronous active-low reset
- c_valid  in  1  input point valid
- c_ready  out  1  engine can accept a point
- c_re  in  WORD_LENGTH  signed real part of c
- c_im  in  WORD_LENGTH  signed imaginary part of c
- x_in  in  11  pixel x tag
- y_in  in  11  pixel y tag
- max_iter  in  ITER_W  iteration limit, sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- iter_count  out  ITER_W  iterations completed before escape/limit
- escaped  out  1  1 = escaped, 0 = hit limit
- x_out  out  11  pixel x tag of result
- y_out  out  11  pixel y tag of result

## Operation
- FSM states: IDLE, ITER, DONE.
- IDLE: c_ready=1. On c_valid && c_ready: latch c_re, c_im, x_in, y_in, max_iter; clear z_re=z_im=0, count=0; go ITER.
- ITER, each cycle in priority order:
  - count == limit → DONE, escaped=0, iter_count=count.
  - |z|² > 4.0 (4 << FRAC) → DONE, escaped=1, iter_count=count.
  - Otherwise z_re ← z_re² − z_im² + c_re, z_im ← 2·z_re·z_im + c_im, count++.
- DONE: out_valid=1; outputs stable until out_valid && out_ready, then IDLE.
- c_ready=0 in ITER and DONE; one point in flight.
- Arithmetic/width:
  - z registers are WORD_LENGTH+2 bits signed.
  - Products are full 2·(WORD_LENGTH+2) bits, arithmetic shift right by FRAC, truncated toward −∞.
  - |z|² sum is taken in full product width before truncation; the escape comparison never wraps.
  - |z| ≤ 2 before any update, so z_new fits without saturation.
- max_iter = 0 → first ITER cycle goes DONE, iter_count=0, escaped=0.
- Input changes while not in IDLE are ignored.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE; c_ready=1 after reset; out_valid=0, escaped=0, iter_count=0, x_out=0, y_out=0; any in-flight point discarded.
- Accept at edge T → ITER from T+1. For a result with count k, out_valid rises at edge T+k+2.
- Minimum turnaround: out_ready high in the first DONE cycle → IDLE next cycle → new accept in the cycle after that.
- out_ready held low: DONE persists indefinitely; all outputs stable.
- Reset asserted in any state overrides the handshake in the same edge.

## Structure
- Shared package mandelbrot_pkg:
  - state enum (IDLE, ITER, DONE)
  - function escape_limit(FRAC) returning 4 << FRAC at product width
  - TAG_W = 11
- One sub-module fx_mul: signed (WORD_LENGTH+2)×(WORD_LENGTH+2) multiply, returns full product and FRAC-shifted result.
- Three instances of fx_mul: z_re², z_im², z_re·z_im.

## Test plan
- Reset: rst_n low 2 cycles mid-ITER → c_ready=1, out_valid=0, all outputs 0 on the first cycle after release.
- c=0+0i, max_iter=100, tag (5,7) → out_valid 102 cycles after accept; iter_count=100, escaped=0, x_out=5, y_out=7.
- c=2.0+0i (0x2000_0000), max_iter=100 → iter_count=2, escaped=1 (|z|²=4 does not escape; 36 does).
- c=−2.0+0i, max_iter=50 → stays on the boundary (z=2 every step); iter_count=50, escaped=0.
- max_iter=0, any c → iter_count=0, escaped=0, out_valid 2 cycles after accept.
- Backpressure: out_ready low 10 cycles with c_valid held high → c_ready stays 0, outputs stable. After out_ready pulses, the next point is accepted exactly one cycle later.
